array_inst_sequencer: RTL
=========================

# array_inst_sequencer

West-edge instruction issuer for the systolic MAC array. It accepts one array command at a time over a valid/ready handshake and expands it into a per-row 4-bit instruction stream and a per-row `os_write` stream, skewed by one cycle per row. While issuing, it strobes the L0 activation/weight buffer and stalls when that buffer is empty. It raises a single-cycle `done` once the last row has received its last instruction.

## Interface
Parameters:
- `row`, 8: number of array rows driven (skew depth).
- `len_bw`, 8: width of the command length field.

Ports:
- `clk` in 1: clock clk.
- `reset` in 1: reset reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: operation. 0 = WS_KERNLD, 1 = WS_EXEC, 2 = OS_EXEC, 3 = OS_FLUSH.
- `cmd_len` in `len_bw`: number of issue cycles (vectors).
- `l0_rd` out 1: L0 read strobe, one per issued vector.
- `l0_empty` in 1: L0 has no data this cycle.
- `inst_w` out 4*`row`: row r instruction in bits [4r+3:4r]. Bit 3 os_flush, bit 2 os_exec, bit 1 ws_exec, bit 0 ws_kernld.
- `os_write` out `row`: per-row accumulator shift enable, used during OS flush.
- `busy` out 1: a command is in progress (not IDLE).
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
  - IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch op and len, load the remaining counter, and go to ISSUE.
  - If `cmd_len`=0, go directly to DRAIN instead, with no issue cycles.
- ISSUE, data ops (WS_KERNLD, WS_EXEC, OS_EXEC):
  - An issue cycle happens when `l0_empty`=0. In an issue cycle, `l0_rd`=1, the row-0 word is set to the op's one-hot bit, and the remaining count decrements.
  - When `l0_empty`=1: `l0_rd`=0, a bubble word (inst 0000, os_write 0) is inserted, and the count holds.
- ISSUE, OS_FLUSH: `l0_empty` is ignored and `l0_rd` stays 0. Every cycle issues inst 1000 with os_write=1.
- When the final issue completes (count reaches 0), go to DRAIN and load the drain counter with `row`.
- DRAIN: issue bubble words. Decrement each cycle. In the cycle the counter reads 1, `done`=1, and the next state is IDLE.
- One-hot encoding: WS_KERNLD→0001, WS_EXEC→0010, OS_EXEC→0100, OS_FLUSH→1000. Exactly one bit is set on an issue cycle; bubbles are 0000.
- `cmd_*` inputs are ignored outside IDLE and must be held by the source until accepted.

## Timing
- Reset values: `inst_w`=0, `os_write`=0, `l0_rd`=0, `done`=0, `busy`=0, `cmd_ready`=1.
  - The skew pipeline clears, state goes to IDLE, and counters go to 0.
- Reset mid-command drops the command with no `done`. The pipeline contents clear on the same edge.
- Command accepted at cycle c; with no stalls, issue cycles are c+1 … c+len. `l0_rd` is combinational from state and `l0_empty`.
- Row-0 word is registered: an issue at cycle t appears on row 0 at t+1, aligned with the 1-cycle L0 read latency. Row r sees it at t+1+r.
- `done` fires at c+len+`row` plus the number of stall cycles. At that cycle row `row`-1 shows its last word.
  - `cmd_ready` returns at the following cycle. There are no back-to-back accepts.
- A stall of k cycles delays all subsequent words and `done` by exactly k.
- `cmd_len` at its maximum (2^`len_bw`−1) runs with no wrap.

## Structure
- Package `array_seq_pkg` holds:
  - op codes (2-bit);
  - inst bit positions / one-hot constants;
  - FSM state enum.
- Sub-module `skew_pipe`: a `row`-deep shift register of 5-bit words (inst + os_write). Tap r drives row r. Synchronous clear on reset.
- The top level contains the FSM, the remaining/drain counters, and the row-0 word register.

## Test plan
- Reset with `row`=8 → `inst_w`=0, `os_write`=0, `cmd_ready`=1, `busy`=0. All stay that way with no command.
- WS_KERNLD, len=3, `l0_empty`=0, accept at c:
  - `l0_rd` high c+1..c+3.
  - Row 0 = 0001 at c+2..c+4; row 7 = 0001 at c+9..c+11.
  - `done` at c+11; `cmd_ready` at c+12.
- WS_EXEC, len=4, `l0_empty`=1 at c+2 and c+3:
  - `l0_rd` low at c+2..c+3.
  - Row 0 reads 0010, 0000, 0000, 0010, 0010, 0010.
  - `done` at c+14.
- OS_FLUSH, len=8 → `l0_rd` never asserted. Row r has inst 1000 and `os_write`[r]=1 at c+2+r..c+9+r. `done` at c+16.
- `cmd_valid` held high during a command → `cmd_ready`=0 until after `done`. The second command is accepted the cycle `cmd_ready` rises, and its first issue follows one cycle later.
- Reset asserted mid WS_EXEC → next cycle all outputs 0 and `cmd_ready`=1, with no `done` pulse ever. A len=0 command then gives `done` at c+8 and no nonzero inst.

Source files
------------

// File: rtl/array_seq_pkg.sv
// Shared op codes, instruction one-hot constants and FSM states for the
// west-edge array instruction sequencer.
package array_seq_pkg;

  localparam logic [1:0] OP_WS_KERNLD = 2'd0;
  localparam logic [1:0] OP_WS_EXEC   = 2'd1;
  localparam logic [1:0] OP_OS_EXEC   = 2'd2;
  localparam logic [1:0] OP_OS_FLUSH  = 2'd3;

  localparam int INST_WS_KERNLD_BIT = 0;
  localparam int INST_WS_EXEC_BIT   = 1;
  localparam int INST_OS_EXEC_BIT   = 2;
  localparam int INST_OS_FLUSH_BIT  = 3;

  localparam logic [3:0] INST_WS_KERNLD = 4'b0001;
  localparam logic [3:0] INST_WS_EXEC   = 4'b0010;
  localparam logic [3:0] INST_OS_EXEC   = 4'b0100;
  localparam logic [3:0] INST_OS_FLUSH  = 4'b1000;
  localparam logic [3:0] INST_BUBBLE    = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  function automatic logic [3:0] op_to_inst(input logic [1:0] op);
    logic [3:0] inst;
    inst = INST_BUBBLE;
    case (op)
      OP_WS_KERNLD: inst = INST_WS_KERNLD;
      OP_WS_EXEC:   inst = INST_WS_EXEC;
      OP_OS_EXEC:   inst = INST_OS_EXEC;
      OP_OS_FLUSH:  inst = INST_OS_FLUSH;
      default:      inst = INST_BUBBLE;
    endcase
    return inst;
  endfunction

endpackage

// File: rtl/array_inst_sequencer_skew_pipe.sv
// Row skew pipeline: tap 0 is the registered row-0 word, tap r lags it by r
// cycles. Each word is {os_write, inst[3:0]}.
module skew_pipe #(
  parameter int row = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           row0_word,
  output logic [4*row-1:0]     inst_w,
  output logic [row-1:0]       os_write
);

  logic [5*(row-1)-1:0] sr;
  logic [5*row-1:0]     chain;

  assign chain = {sr, row0_word};

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= chain[5*row-6:0];
  end

  for (genvar r = 0; r < row; r++) begin : g_tap
    assign inst_w[4*r +: 4] = chain[5*r +: 4];
    assign os_write[r]      = chain[5*r+4];
  end

endmodule

// File: rtl/array_inst_sequencer.sv
// West-edge instruction issuer: expands one command into a row-skewed
// instruction / os_write stream, strobing L0 and stalling on empty.
module array_inst_sequencer
  import array_seq_pkg::*;
#(
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [len_bw-1:0]  cmd_len,
  output logic               l0_rd,
  input  logic               l0_empty,
  output logic [4*row-1:0]   inst_w,
  output logic [row-1:0]     os_write,
  output logic               busy,
  output logic               done
);

  localparam int DW = $clog2(row + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(row);

  seq_state_t         state, state_next;
  logic [1:0]         op_q, op_next;
  logic [len_bw-1:0]  rem_cnt, rem_next;
  logic [DW-1:0]      drain_cnt, drain_next;
  logic [4:0]         row0_word, word_next;
  logic               issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_WS_KERNLD;
      rem_cnt   <= '0;
      drain_cnt <= '0;
      row0_word <= '0;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      rem_cnt   <= rem_next;
      drain_cnt <= drain_next;
      row0_word <= word_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    rem_next   = rem_cnt;
    drain_next = drain_cnt;
    word_next  = '0;
    issue      = 1'b0;
    l0_rd      = 1'b0;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_next = cmd_op;
          if (cmd_len == '0) begin
            drain_next = DRAIN_LOAD;
            state_next = ST_DRAIN;
          end else begin
            rem_next   = cmd_len;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Flush shifts accumulators out regardless of L0 occupancy.
        if (op_q == OP_OS_FLUSH) begin
          issue = 1'b1;
        end else if (!l0_empty) begin
          issue = 1'b1;
          l0_rd = 1'b1;
        end
        if (issue) begin
          word_next = {op_q == OP_OS_FLUSH, op_to_inst(op_q)};
          rem_next  = rem_cnt - 1'b1;
          if (rem_cnt == len_bw'(1)) begin
            drain_next = DRAIN_LOAD;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_next = drain_cnt - 1'b1;
        if (drain_cnt == DW'(1)) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  skew_pipe #(.row(row)) u_skew (
    .clk       (clk),
    .reset     (reset),
    .row0_word (row0_word),
    .inst_w    (inst_w),
    .os_write  (os_write)
  );

endmodule
